lamp_seq_monitor: RTL and testbench

Passive checker on the lamp outputs of the traffic-light controller. It samples red/yellow/green every clock and decodes the lamp pattern into a phase. It checks that phases follow the order RED → RED+YELLOW → GREEN → YELLOW → RED and that each phase lasts exactly its programmed number of cycles. It reports the current phase, one-cycle error pulses, a sticky fault flag and a completed-cycle count, and sits beside the controller in the top level and testbench.

---
 rtl/lamp_seq_monitor.sv | 155 +++++++++++++++
 tb/tb_lamp_seq_monitor.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/lamp_seq_monitor.sv
// Passive checker for traffic-light lamp outputs: decodes the lamp pattern into a phase,
// checks phase order and per-phase duration, and counts completed light cycles.
module lamp_seq_monitor #(
   parameter int unsigned R_T   = 10000,
   parameter int unsigned RY_T  = 5000,
   parameter int unsigned G_T   = 10000,
   parameter int unsigned Y_T   = 5000,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             red_in,
   input  logic             yellow_in,
   input  logic             green_in,
   output logic [2:0]       phase,
   output logic             locked,
   output logic             err_illegal,
   output logic             err_order,
   output logic             err_timing,
   output logic             fault,
   output logic [CNT_W-1:0] cycle_cnt
);

   typedef enum logic [2:0] {
      StSync   = 3'd0,
      StRed    = 3'd1,
      StRedYel = 3'd2,
      StGreen  = 3'd3,
      StYel    = 3'd4,
      StFault  = 3'd7
   } state_e;

   state_e           state_q, state_d;
   state_e           pat_ph, succ;
   logic             pat_legal;
   logic [15:0]      dur_q, dur_d, t_cur;
   logic             skip_q, skip_d;
   logic             ovr_q, ovr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ill_q, ill_d, ord_q, ord_d, tim_q, tim_d;
   logic             fault_q, fault_d;

   // Lamp pattern decode, successor phase and programmed duration of the current phase
   always_comb begin
      pat_legal = 1'b1;
      unique case ({red_in, yellow_in, green_in})
         3'b100:  pat_ph = StRed;
         3'b110:  pat_ph = StRedYel;
         3'b001:  pat_ph = StGreen;
         3'b010:  pat_ph = StYel;
         default: begin
            pat_ph    = StSync;
            pat_legal = 1'b0;
         end
      endcase

      case (state_q)
         StRed:    begin succ = StRedYel; t_cur = 16'(R_T);  end
         StRedYel: begin succ = StGreen;  t_cur = 16'(RY_T); end
         StGreen:  begin succ = StYel;    t_cur = 16'(G_T);  end
         StYel:    begin succ = StRed;    t_cur = 16'(Y_T);  end
         default:  begin succ = StFault;  t_cur = 16'd0;     end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StSync;
         dur_q   <= '0;
         skip_q  <= 1'b0;
         ovr_q   <= 1'b0;
         cnt_q   <= '0;
         ill_q   <= 1'b0;
         ord_q   <= 1'b0;
         tim_q   <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         dur_q   <= dur_d;
         skip_q  <= skip_d;
         ovr_q   <= ovr_d;
         cnt_q   <= cnt_d;
         ill_q   <= ill_d;
         ord_q   <= ord_d;
         tim_q   <= tim_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      dur_d   = dur_q;
      skip_d  = skip_q;
      ovr_d   = ovr_q;
      cnt_d   = cnt_q;
      ill_d   = 1'b0;
      ord_d   = 1'b0;
      tim_d   = 1'b0;
      if (clr) begin
         state_d = StSync;
         dur_d   = '0;
         skip_d  = 1'b0;
         ovr_d   = 1'b0;
      end else begin
         case (state_q)
            StSync: begin
               // First legal sample may land mid-phase, so its duration is not checked
               if (pat_legal) begin
                  state_d = pat_ph;
                  dur_d   = 16'd1;
                  skip_d  = 1'b1;
                  ovr_d   = 1'b0;
               end
            end
            StRed, StRedYel, StGreen, StYel: begin
               if (!pat_legal) begin
                  ill_d   = 1'b1;
                  state_d = StFault;
               end else if (pat_ph == state_q) begin
                  dur_d = (dur_q == 16'hFFFF) ? dur_q : dur_q + 16'd1;
                  if (dur_q == t_cur && !skip_q && !ovr_q) begin
                     tim_d = 1'b1;
                     ovr_d = 1'b1;
                  end
               end else if (pat_ph == succ) begin
                  if (!skip_q && !ovr_q && dur_q != t_cur) tim_d = 1'b1;
                  state_d = pat_ph;
                  dur_d   = 16'd1;
                  skip_d  = 1'b0;
                  ovr_d   = 1'b0;
                  if (state_q == StYel) cnt_d = cnt_q + CNT_W'(1);
               end else begin
                  ord_d   = 1'b1;
                  state_d = StFault;
               end
            end
            default: ;
         endcase
      end
      fault_d = clr ? 1'b0 : (fault_q | ill_d | ord_d | tim_d);
   end

   always_comb begin
      phase       = state_q;
      locked      = (state_q == StRed) || (state_q == StRedYel) ||
                    (state_q == StGreen) || (state_q == StYel);
      err_illegal = ill_q;
      err_order   = ord_q;
      err_timing  = tim_q;
      fault       = fault_q;
      cycle_cnt   = cnt_q;
   end

endmodule

// File: tb/tb_lamp_seq_monitor.sv
// Table-driven bench for lamp_seq_monitor with short phase durations and a 2-bit cycle counter.
module tb_lamp_seq_monitor;

   localparam logic [2:0] PatR   = 3'b100;
   localparam logic [2:0] PatRY  = 3'b110;
   localparam logic [2:0] PatG   = 3'b001;
   localparam logic [2:0] PatY   = 3'b010;
   localparam logic [2:0] PatAll = 3'b111;
   localparam logic [2:0] PatOff = 3'b000;
   localparam logic [2:0] ENone  = 3'b000;
   localparam logic [2:0] ETim   = 3'b001;
   localparam logic [2:0] EOrd   = 3'b010;
   localparam logic [2:0] EIll   = 3'b100;

   logic       clk, reset, clr, red_in, yellow_in, green_in;
   logic [2:0] phase;
   logic       locked, err_illegal, err_order, err_timing, fault;
   logic [1:0] cycle_cnt;

   lamp_seq_monitor #(
      .R_T   (4),
      .RY_T  (2),
      .G_T   (4),
      .Y_T   (2),
      .CNT_W (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .clr         (clr),
      .red_in      (red_in),
      .yellow_in   (yellow_in),
      .green_in    (green_in),
      .phase       (phase),
      .locked      (locked),
      .err_illegal (err_illegal),
      .err_order   (err_order),
      .err_timing  (err_timing),
      .fault       (fault),
      .cycle_cnt   (cycle_cnt)
   );

   // err field is {illegal, order, timing}
   typedef struct {
      logic [2:0] pat;
      logic       clr;
      logic [2:0] ph;
      logic [2:0] err;
      logic       flt;
      logic [1:0] cnt;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   int   total = 0;
   int   bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic [2:0] pat, input logic c, input logic [2:0] ph,
                      input logic [2:0] err, input logic flt, input logic [1:0] cnt);
      vec_t v;
      v.pat = pat; v.clr = c; v.ph = ph; v.err = err; v.flt = flt; v.cnt = cnt;
      vecs.push_back(v);
   endtask

   task automatic add_run(input logic [2:0] pat, input int n, input logic [2:0] ph,
                          input logic flt, input logic [1:0] cnt);
      for (int i = 0; i < n; i++) add(pat, 1'b0, ph, ENone, flt, cnt);
   endtask

   task automatic check_sb(input string tag, input int idx);
      vec_t       e;
      logic       exp_lk;
      logic [2:0] got_err;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("FAIL %s[%0d]: scoreboard empty", tag, idx);
      end else begin
         e       = sb.pop_front();
         exp_lk  = (e.ph >= 3'd1) && (e.ph <= 3'd4);
         got_err = {err_illegal, err_order, err_timing};
         if (phase !== e.ph || locked !== exp_lk || got_err !== e.err ||
             fault !== e.flt || cycle_cnt !== e.cnt) begin
            bad++;
            $display("FAIL %s[%0d]: got ph=%0d lk=%b err=%b flt=%b cnt=%0d, want ph=%0d lk=%b err=%b flt=%b cnt=%0d",
                     tag, idx, phase, locked, got_err, fault, cycle_cnt,
                     e.ph, exp_lk, e.err, e.flt, e.cnt);
         end
      end
   endtask

   task automatic run_vecs(input string tag);
      for (int i = 0; i < vecs.size(); i++) begin
         {red_in, yellow_in, green_in} = vecs[i].pat;
         clr = vecs[i].clr;
         sb.push_back(vecs[i]);
         @(posedge clk);
         #1;
         check_sb(tag, i);
      end
      vecs.delete();
      clr = 1'b0;
   endtask

   task automatic check_rst(input string tag);
      total++;
      if (phase !== 3'd0 || locked !== 1'b0 || err_illegal !== 1'b0 || err_order !== 1'b0 ||
          err_timing !== 1'b0 || fault !== 1'b0 || cycle_cnt !== 2'd0) begin
         bad++;
         $display("FAIL %s: got ph=%0d lk=%b err=%b%b%b flt=%b cnt=%0d, want all zero",
                  tag, phase, locked, err_illegal, err_order, err_timing, fault, cycle_cnt);
      end
   endtask

   initial begin
      reset = 1'b1; clr = 1'b0;
      red_in = 1'b0; yellow_in = 1'b0; green_in = 1'b0;
      #12;
      check_rst("reset_values");
      @(negedge clk);
      reset = 1'b0;

      // Two nominal cycles from reset
      for (int k = 0; k < 2; k++) begin
         add_run(PatR, 4, 3'd1, 1'b0, 2'(k));
         add_run(PatRY, 2, 3'd2, 1'b0, 2'(k));
         add_run(PatG, 4, 3'd3, 1'b0, 2'(k));
         add_run(PatY, 2, 3'd4, 1'b0, 2'(k));
      end
      // GREEN overrun flagged on the 5th sample only
      add_run(PatR, 4, 3'd1, 1'b0, 2'd2);
      add_run(PatRY, 2, 3'd2, 1'b0, 2'd2);
      add_run(PatG, 4, 3'd3, 1'b0, 2'd2);
      add(PatG, 1'b0, 3'd3, ETim, 1'b1, 2'd2);
      add_run(PatY, 2, 3'd4, 1'b1, 2'd2);
      // RED underrun at the change to REDYEL
      add_run(PatR, 3, 3'd1, 1'b1, 2'd3);
      add(PatRY, 1'b0, 3'd2, ETim, 1'b1, 2'd3);
      add(PatRY, 1'b1, 3'd0, ENone, 1'b0, 2'd3);
      // Order error, inputs ignored in FAULT, clr and relock
      add_run(PatR, 2, 3'd1, 1'b0, 2'd3);
      add(PatG, 1'b0, 3'd7, EOrd, 1'b1, 2'd3);
      add(PatR, 1'b0, 3'd7, ENone, 1'b1, 2'd3);
      add(PatY, 1'b0, 3'd7, ENone, 1'b1, 2'd3);
      add(PatAll, 1'b0, 3'd7, ENone, 1'b1, 2'd3);
      add(PatOff, 1'b1, 3'd0, ENone, 1'b0, 2'd3);
      add_run(PatR, 4, 3'd1, 1'b0, 2'd3);
      add_run(PatRY, 1, 3'd2, 1'b0, 2'd3);
      // Illegal pattern while tracking, then illegal patterns ignored in SYNC
      add(PatAll, 1'b0, 3'd7, EIll, 1'b1, 2'd3);
      add(PatOff, 1'b1, 3'd0, ENone, 1'b0, 2'd3);
      add(PatOff, 1'b0, 3'd0, ENone, 1'b0, 2'd3);
      add(3'b011, 1'b0, 3'd0, ENone, 1'b0, 2'd3);
      add(3'b101, 1'b0, 3'd0, ENone, 1'b0, 2'd3);
      // clr at the same edge as an illegal pattern suppresses the pulse
      add(PatR, 1'b0, 3'd1, ENone, 1'b0, 2'd3);
      add(PatAll, 1'b1, 3'd0, ENone, 1'b0, 2'd3);
      add(PatR, 1'b0, 3'd1, ENone, 1'b0, 2'd3);
      // Short REDYEL after a skipped RED, leaving fault set before the reset
      add(PatRY, 1'b0, 3'd2, ENone, 1'b0, 2'd3);
      add(PatG, 1'b0, 3'd3, ETim, 1'b1, 2'd3);
      add(PatG, 1'b0, 3'd3, ENone, 1'b1, 2'd3);
      run_vecs("seq");

      // Asynchronous reset mid-GREEN
      #2;
      reset = 1'b1;
      #1;
      check_rst("async_reset");
      @(posedge clk);
      #1;
      check_rst("reset_held");
      reset = 1'b0;

      // Five nominal cycles: 2-bit counter wraps 1,2,3,0,1
      for (int k = 0; k < 5; k++) begin
         add_run(PatR, 4, 3'd1, 1'b0, 2'(k));
         add_run(PatRY, 2, 3'd2, 1'b0, 2'(k));
         add_run(PatG, 4, 3'd3, 1'b0, 2'(k));
         add_run(PatY, 2, 3'd4, 1'b0, 2'(k));
      end
      add(PatR, 1'b0, 3'd1, ENone, 1'b0, 2'd1);
      run_vecs("wrap");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
